// File: rtl/column_mux_seq_if.sv
// Column-mux control/status bundle: the scan controls (enable, sync)
// and the registered column-drive outputs seen by the driver-data path.
interface column_mux_seq_if #(
    parameter int NB_COLUMNS = 8
) ();

    localparam int IDX_W = $clog2(NB_COLUMNS);

    logic                  enable;
    logic                  framebuffer_sync;
    logic [NB_COLUMNS-1:0] mux_out;
    logic [IDX_W-1:0]      col_idx;
    logic                  col_start;
    logic                  seq_done;
    logic                  busy;

    // Sync/enable source side (framebuffer logic, testbench)
    modport master (
        output enable,
        output framebuffer_sync,
        input  mux_out,
        input  col_idx,
        input  col_start,
        input  seq_done,
        input  busy
    );

    // Column multiplexer side
    modport slave (
        input  enable,
        input  framebuffer_sync,
        output mux_out,
        output col_idx,
        output col_start,
        output seq_done,
        output busy
    );

endinterface

// File: rtl/column_mux_seq.sv
// Column multiplexer for the LED-panel column MOSFETs.
// Each framebuffer_sync starts a scan of NB_COLUMNS columns; every column
// is preceded by BLANK_CYCLES all-off cycles (break-before-make) and then
// driven for DRIVE_CYCLES cycles. The scan stops after the last column
// (ONE_SHOT=1) or wraps to column 0 (ONE_SHOT=0). All outputs are
// registered: the next-state logic also computes next output values.
module column_mux_seq #(
    parameter int NB_COLUMNS   = 8,
    parameter int DRIVE_CYCLES = 330,
    parameter int BLANK_CYCLES = 4,
    parameter int ONE_SHOT     = 1
) (
    input  logic              clk_33,
    input  logic              rst,
    column_mux_seq_if.slave   cm_bus
);

    localparam int IDX_W   = $clog2(NB_COLUMNS);
    localparam int CNT_TOP = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CNT_MAX = (CNT_TOP > 1) ? CNT_TOP : 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_COL   = IDX_W'(NB_COLUMNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_col;
    logic [NB_COLUMNS-1:0] r_mux;
    logic                  r_col_start;
    logic                  r_seq_done;
    logic                  r_busy;

    state_t                w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [IDX_W-1:0]      w_col_next;
    logic [NB_COLUMNS-1:0] w_mux_next;
    logic                  w_col_start_next;
    logic                  w_seq_done_next;
    logic                  w_busy_next;
    logic                  w_begin_col;
    logic                  w_enter_drive;

    assign cm_bus.mux_out   = r_mux;
    assign cm_bus.col_idx   = r_col;
    assign cm_bus.col_start = r_col_start;
    assign cm_bus.seq_done  = r_seq_done;
    assign cm_bus.busy      = r_busy;

    // Next state, counter, column index and next registered outputs.
    // w_begin_col marks the first cycle of a column (sync start or advance);
    // it resolves to BLANK, or straight to DRIVE when there is no blanking.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_col_next      = r_col;
        w_seq_done_next = 1'b0;
        w_begin_col     = 1'b0;
        w_enter_drive   = 1'b0;

        if (!cm_bus.enable) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_col_next   = '0;
        end else if (cm_bus.framebuffer_sync) begin
            // Restart wins over any end-of-column / end-of-scan transition
            w_cnt_next  = '0;
            w_col_next  = '0;
            w_begin_col = 1'b1;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_next  = ST_DRIVE;
                        w_cnt_next    = '0;
                        w_enter_drive = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == DRIVE_LAST) begin
                        w_cnt_next = '0;
                        if (r_col != LAST_COL) begin
                            w_col_next  = r_col + 1'b1;
                            w_begin_col = 1'b1;
                        end else begin
                            w_seq_done_next = 1'b1;
                            w_col_next      = '0;
                            if (ONE_SHOT != 0) begin
                                w_state_next = ST_IDLE;
                            end else begin
                                w_begin_col = 1'b1;
                            end
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end

        if (w_begin_col) begin
            if (BLANK_CYCLES == 0) begin
                w_state_next  = ST_DRIVE;
                w_enter_drive = 1'b1;
            end else begin
                w_state_next = ST_BLANK;
            end
        end

        w_mux_next = '0;
        if (w_state_next == ST_DRIVE) begin
            for (int unsigned i = 0; i < NB_COLUMNS; i++) begin
                w_mux_next[i] = (w_col_next == IDX_W'(i));
            end
        end
        w_col_start_next = w_enter_drive;
        w_busy_next      = (w_state_next != ST_IDLE);
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk_33) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_col       <= '0;
            r_mux       <= '0;
            r_col_start <= 1'b0;
            r_seq_done  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_col       <= w_col_next;
            r_mux       <= w_mux_next;
            r_col_start <= w_col_start_next;
            r_seq_done  <= w_seq_done_next;
            r_busy      <= w_busy_next;
        end
    end

endmodule

// File: tb/tb_column_mux_seq.sv
// Testbench for column_mux_seq: three configurations driven by shared
// stimulus and compared against a timeline model of the column scan.
module tb_column_mux_seq;

    localparam int CN [3] = '{4, 4, 8};
    localparam int CD [3] = '{5, 5, 1};
    localparam int CB [3] = '{2, 2, 0};
    localparam int CO [3] = '{1, 0, 1};

    logic clk_33 = 1'b0;
    logic rst    = 1'b1;

    always #5 clk_33 = ~clk_33;

    column_mux_seq_if #(.NB_COLUMNS(4)) if_a ();
    column_mux_seq_if #(.NB_COLUMNS(4)) if_b ();
    column_mux_seq_if #(.NB_COLUMNS(8)) if_c ();

    column_mux_seq #(.NB_COLUMNS(4), .DRIVE_CYCLES(5), .BLANK_CYCLES(2), .ONE_SHOT(1))
        u_dut_a (.clk_33(clk_33), .rst(rst), .cm_bus(if_a));
    column_mux_seq #(.NB_COLUMNS(4), .DRIVE_CYCLES(5), .BLANK_CYCLES(2), .ONE_SHOT(0))
        u_dut_b (.clk_33(clk_33), .rst(rst), .cm_bus(if_b));
    column_mux_seq #(.NB_COLUMNS(8), .DRIVE_CYCLES(1), .BLANK_CYCLES(0), .ONE_SHOT(1))
        u_dut_c (.clk_33(clk_33), .rst(rst), .cm_bus(if_c));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit act      = 1'b0;
    int st       = 0;
    int last_mux [3] = '{0, 0, 0};
    int zeros    [3] = '{0, 0, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Expected outputs m cycles after the edge that sampled the starting sync
    function automatic void model(input int i, input bit a, input int m,
                                  output int mux, output int idx, output int cs,
                                  output int sd, output int bsy);
        int p, k, o;
        mux = 0; idx = 0; cs = 0; sd = 0; bsy = 0;
        if (!a) return;
        p = CB[i] + CD[i];
        if (CO[i] != 0 && m >= CN[i] * p) begin
            sd = (m == CN[i] * p) ? 1 : 0;
            return;
        end
        k   = m / p;
        o   = m % p;
        idx = k % CN[i];
        bsy = 1;
        if (o >= CB[i]) mux = 1 << idx;
        cs  = (o == CB[i]) ? 1 : 0;
        sd  = (m > 0 && (m % (CN[i] * p)) == 0) ? 1 : 0;
    endfunction

    task automatic sample();
        logic [31:0] gm [3], gi [3], gc [3], gs [3], gb [3];
        int em, ei, ec, es, eb;
        string nm;
        gm[0] = 32'(if_a.mux_out); gi[0] = 32'(if_a.col_idx); gc[0] = 32'(if_a.col_start);
        gs[0] = 32'(if_a.seq_done); gb[0] = 32'(if_a.busy);
        gm[1] = 32'(if_b.mux_out); gi[1] = 32'(if_b.col_idx); gc[1] = 32'(if_b.col_start);
        gs[1] = 32'(if_b.seq_done); gb[1] = 32'(if_b.busy);
        gm[2] = 32'(if_c.mux_out); gi[2] = 32'(if_c.col_idx); gc[2] = 32'(if_c.col_start);
        gs[2] = 32'(if_c.seq_done); gb[2] = 32'(if_c.busy);
        for (int i = 0; i < 3; i++) begin
            nm = $sformatf("cfg%0d@%0d", i, cyc);
            model(i, act, cyc - st, em, ei, ec, es, eb);
            check_eq({nm, ".mux_out"},   gm[i], em);
            check_eq({nm, ".col_idx"},   gi[i], ei);
            check_eq({nm, ".col_start"}, gc[i], ec);
            check_eq({nm, ".seq_done"},  gs[i], es);
            check_eq({nm, ".busy"},      gb[i], eb);
            check_eq({nm, ".onehot0"},   32'($onehot0(gm[i])), 1);
            if (gm[i] == 0) begin
                zeros[i]++;
            end else begin
                if (CB[i] > 0 && last_mux[i] != 0 && int'(gm[i]) != last_mux[i])
                    check_eq({nm, ".blank_gap"}, 32'(zeros[i] >= CB[i]), 1);
                last_mux[i] = int'(gm[i]);
                zeros[i]    = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s);
        rst = r;
        if_a.enable = e; if_a.framebuffer_sync = s;
        if_b.enable = e; if_b.framebuffer_sync = s;
        if_c.enable = e; if_c.framebuffer_sync = s;
        @(posedge clk_33);
        cyc++;
        if (r || !e) act = 1'b0;
        else if (s) begin
            act = 1'b1;
            st  = cyc;
        end
        #1;
        sample();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("reset.mux_a", 32'(if_a.mux_out), 0);
        check_eq("reset.busy_a", 32'(if_a.busy), 0);

        // Single scan from one sync; spot values from the scan timeline
        for (int r = 0; r < 45; r++) begin
            step(1'b0, 1'b1, r == 0);
            if (r == 2)  check_eq("scan.a.c3.mux", 32'(if_a.mux_out), 32'h1);
            if (r == 2)  check_eq("scan.a.c3.start", 32'(if_a.col_start), 1);
            if (r == 9)  check_eq("scan.a.c10.mux", 32'(if_a.mux_out), 32'h2);
            if (r == 23) check_eq("scan.a.c24.mux", 32'(if_a.mux_out), 32'h8);
            if (r == 28) check_eq("scan.a.c29.done", 32'(if_a.seq_done), 1);
            if (r == 28) check_eq("scan.b.c29.done", 32'(if_b.seq_done), 1);
            if (r == 30) check_eq("scan.b.c31.mux", 32'(if_b.mux_out), 32'h1);
            if (r == 30) check_eq("scan.a.c31.mux", 32'(if_a.mux_out), 0);
            if (r == 0)  check_eq("scan.c.c1.mux", 32'(if_c.mux_out), 32'h01);
            if (r == 7)  check_eq("scan.c.c8.mux", 32'(if_c.mux_out), 32'h80);
            if (r == 8)  check_eq("scan.c.c9.done", 32'(if_c.seq_done), 1);
        end

        // Restart while column 1 is driving
        do_reset();
        for (int r = 0; r < 45; r++) begin
            step(1'b0, 1'b1, r == 0 || r == 12);
            if (r == 12) check_eq("restart.c13.mux", 32'(if_a.mux_out), 0);
            if (r == 14) check_eq("restart.c15.mux", 32'(if_a.mux_out), 32'h1);
            if (r == 27) check_eq("restart.c28.done", 32'(if_a.seq_done), 0);
        end

        // Enable dropped mid-scan; sync while disabled is ignored
        do_reset();
        for (int r = 0; r < 40; r++) begin
            step(1'b0, !(r >= 5 && r <= 8), r == 0 || r == 7);
            if (r == 5) check_eq("disable.c6.busy", 32'(if_a.busy), 0);
            if (r == 7) check_eq("disable.c8.busy", 32'(if_a.busy), 0);
        end

        // Reset mid-drive
        do_reset();
        for (int r = 0; r < 20; r++) begin
            step(r == 4, 1'b1, r == 0);
            if (r == 4) check_eq("rst.c5.mux", 32'(if_a.mux_out), 0);
        end

        // Random sync / enable / reset stress
        do_reset();
        for (int r = 0; r < 3000; r++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 29) != 0,
                 $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
